// File: rtl/conv554_sched_pkg.sv
// Shared definitions for the C3 5x5x4 convolution sequencer:
// FSM state encoding, the result tag bundle and kernel geometry.
package conv554_sched_pkg;

    localparam int KSIZE  = 5;
    localparam int NCHAN  = 4;
    localparam int TAG_FW = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Field width is fixed here; the top truncates to its own widths.
    typedef struct packed {
        logic [TAG_FW-1:0] map;
        logic [TAG_FW-1:0] row;
        logic [TAG_FW-1:0] col;
    } tag_t;

endpackage

// File: rtl/conv554_sched_tag_delay_line.sv
// Valid + tag shift pipeline of DEPTH stages (DEPTH=0 is a wire).
// Ports: clk, rst_n, flush (clears valids), vld_i/tag_i in, vld_o/tag_o out.
module tag_delay_line
    import conv554_sched_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic vld_i,
    input  tag_t tag_i,
    output logic vld_o,
    output tag_t tag_o
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctl;
        assign unused_ctl = ^{clk, rst_n, flush};
        assign vld_o = vld_i;
        assign tag_o = tag_i;
    end else begin : g_pipe
        logic [DEPTH-1:0] vld_q;
        logic [DEPTH-1:0] vld_d;
        tag_t             tag_q [DEPTH];
        tag_t             tag_d [DEPTH];

        always_comb begin
            vld_d[0] = vld_i;
            tag_d[0] = tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_d[i] = vld_q[i-1];
                tag_d[i] = tag_q[i-1];
            end
            if (flush) begin
                vld_d = '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    tag_q[i] <= '0;
                end
            end else begin
                vld_q <= vld_d;
                for (int i = 0; i < DEPTH; i++) begin
                    tag_q[i] <= tag_d[i];
                end
            end
        end

        assign vld_o = vld_q[DEPTH-1];
        assign tag_o = tag_q[DEPTH-1];
    end

endmodule

// File: rtl/conv554_sched.sv
// C3 layer sequencer: walks map/row/column, issues buffer reads,
// aligns the datapath enable and tags each valid convolution result.
// Ports: start/abort in; busy/done; rd_en/rd_row/rd_col buffer request;
// conv_en/map_sel datapath control; out_valid/out_map/out_row/out_col.
module conv554_sched
    import conv554_sched_pkg::*;
#(
    parameter int IN_W     = 14,
    parameter int IN_H     = 14,
    parameter int N_MAP    = 16,
    parameter int RD_LAT   = 1,
    parameter int CONV_LAT = 1,
    localparam int OUT_H   = IN_H - 4,
    localparam int COL_W   = $clog2(IN_W),
    localparam int ROW_W   = $clog2(IN_H),
    localparam int MAP_W   = (N_MAP > 1) ? $clog2(N_MAP) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [ROW_W-1:0] rd_row,
    output logic [COL_W-1:0] rd_col,
    output logic             conv_en,
    output logic [MAP_W-1:0] map_sel,
    output logic             out_valid,
    output logic [MAP_W-1:0] out_map,
    output logic [ROW_W-1:0] out_row,
    output logic [COL_W-1:0] out_col
);

    localparam logic [COL_W-1:0] C_LAST = COL_W'(IN_W - 1);
    localparam logic [ROW_W-1:0] R_LAST = ROW_W'(OUT_H - 1);
    localparam logic [MAP_W-1:0] M_LAST = MAP_W'(N_MAP - 1);
    // Fixed pipeline latency: counting it out equals waiting for empty.
    localparam logic [7:0] DRAIN_INIT = 8'(RD_LAT + CONV_LAT - 1);
    localparam logic [TAG_FW-1:0] FILL = TAG_FW'(KSIZE - 1);

    state_t           state_q, state_d;
    logic [MAP_W-1:0] m_q, m_d;
    logic [ROW_W-1:0] r_q, r_d;
    logic [COL_W-1:0] c_q, c_d;
    logic [7:0]       drain_q, drain_d;
    logic [MAP_W-1:0] map_hold_q, map_hold_d;

    logic run;
    logic last_rd;

    assign run     = (state_q == ST_RUN);
    assign last_rd = run && (c_q == C_LAST) && (r_q == R_LAST)
                     && (m_q == M_LAST);

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        r_d     = r_q;
        c_d     = c_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_IDLE: begin
                m_d = '0;
                r_d = '0;
                c_d = '0;
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (c_q == C_LAST) begin
                    c_d = '0;
                    if (r_q == R_LAST) begin
                        r_d = '0;
                        m_d = (m_q == M_LAST) ? '0 : m_q + 1'b1;
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                end else begin
                    c_d = c_q + 1'b1;
                end
                if (last_rd) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = ST_DONE;
                else drain_d = drain_q - 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            m_d     = '0;
            r_d     = '0;
            c_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            m_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            drain_q    <= '0;
            map_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            r_q        <= r_d;
            c_q        <= c_d;
            drain_q    <= drain_d;
            map_hold_q <= map_hold_d;
        end
    end

    tag_t rd_tag_in, rd_tag, cv_tag_in, cv_tag;
    logic rd_vld, cv_vld_in, cv_vld;

    assign rd_tag_in = '{map: TAG_FW'(m_q),
                         row: TAG_FW'(r_q),
                         col: TAG_FW'(c_q)};

    tag_delay_line #(.DEPTH(RD_LAT)) u_rd_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort),
        .vld_i (run),
        .tag_i (rd_tag_in),
        .vld_o (rd_vld),
        .tag_o (rd_tag)
    );

    // First KSIZE-1 columns of each row only refill the window.
    assign cv_vld_in = rd_vld && (rd_tag.col >= FILL);
    assign cv_tag_in = '{map: rd_tag.map,
                         row: rd_tag.row,
                         col: rd_tag.col - FILL};

    tag_delay_line #(.DEPTH(CONV_LAT)) u_cv_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort),
        .vld_i (cv_vld_in),
        .tag_i (cv_tag_in),
        .vld_o (cv_vld),
        .tag_o (cv_tag)
    );

    assign conv_en    = rd_vld;
    assign map_sel    = rd_vld ? MAP_W'(rd_tag.map) : map_hold_q;
    assign map_hold_d = map_sel;

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign rd_en     = run;
    assign rd_row    = r_q;
    assign rd_col    = c_q;
    assign out_valid = cv_vld;
    assign out_map   = cv_vld ? MAP_W'(cv_tag.map) : '0;
    assign out_row   = cv_vld ? ROW_W'(cv_tag.row) : '0;
    assign out_col   = cv_vld ? COL_W'(cv_tag.col) : '0;

    logic unused_tag;
    assign unused_tag = ^{rd_tag, cv_tag};

endmodule

// File: tb/tb_conv554_sched.sv
// Directed bench for conv554_sched: three instances (N_MAP=1, N_MAP=2,
// RD_LAT=3/CONV_LAT=0) share stimulus; cycle 0 is the start cycle.
module tb_conv554_sched;

    logic clk = 1'b0;
    logic rst_n, start, abort;
    always #5 clk = ~clk;

    logic       a_busy, a_done, a_rd_en, a_conv_en, a_ov;
    logic [3:0] a_rd_row, a_rd_col, a_orow, a_ocol;
    logic [0:0] a_msel, a_omap;
    logic       b_busy, b_done, b_rd_en, b_conv_en, b_ov;
    logic [3:0] b_rd_row, b_rd_col, b_orow, b_ocol;
    logic [0:0] b_msel, b_omap;
    logic       c_busy, c_done, c_rd_en, c_conv_en, c_ov;
    logic [3:0] c_rd_row, c_rd_col, c_orow, c_ocol;
    logic [0:0] c_msel, c_omap;

    conv554_sched #(.N_MAP(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(a_busy), .done(a_done), .rd_en(a_rd_en),
        .rd_row(a_rd_row), .rd_col(a_rd_col), .conv_en(a_conv_en),
        .map_sel(a_msel), .out_valid(a_ov), .out_map(a_omap),
        .out_row(a_orow), .out_col(a_ocol));

    conv554_sched #(.N_MAP(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(b_busy), .done(b_done), .rd_en(b_rd_en),
        .rd_row(b_rd_row), .rd_col(b_rd_col), .conv_en(b_conv_en),
        .map_sel(b_msel), .out_valid(b_ov), .out_map(b_omap),
        .out_row(b_orow), .out_col(b_ocol));

    conv554_sched #(.N_MAP(1), .RD_LAT(3), .CONV_LAT(0)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(c_busy), .done(c_done), .rd_en(c_rd_en),
        .rd_row(c_rd_row), .rd_col(c_rd_col), .conv_en(c_conv_en),
        .map_sel(c_msel), .out_valid(c_ov), .out_map(c_omap),
        .out_row(c_orow), .out_col(c_ocol));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int tagv(input int m, input int r, input int c);
        return m * 10000 + r * 100 + c;
    endfunction

    int a_rd_n, a_rd_first, a_rd_last;
    int a_v_n, a_v_first, a_v_first_tag, a_tag21;
    int a_v_last, a_v_last_tag, a_done_n, a_done_cyc, a_busy_low;
    int a_v2_first, a_v2_tag;
    int b_v_n, b_ms141, b_ms142, b_ce142, b_m1_first, b_m1_tag;
    int c_v_n, c_v_first, c_v_first_tag, c_col_bad;
    int ab_bad, early_done, rs_bad;

    task automatic run_pass(input int st2, input int ab,
                            input int rs, input int ncyc);
        int tg;
        a_rd_n = 0; a_rd_first = -1; a_rd_last = -1;
        a_v_n = 0; a_v_first = -1; a_v_first_tag = -1; a_tag21 = -1;
        a_v_last = -1; a_v_last_tag = -1;
        a_done_n = 0; a_done_cyc = -1; a_busy_low = -1;
        a_v2_first = -1; a_v2_tag = -1;
        b_v_n = 0; b_ms141 = -1; b_ms142 = -1; b_ce142 = -1;
        b_m1_first = -1; b_m1_tag = -1;
        c_v_n = 0; c_v_first = -1; c_v_first_tag = -1; c_col_bad = 0;
        ab_bad = 0; early_done = 0; rs_bad = 0;
        for (int rel = 0; rel < ncyc; rel++) begin
            @(negedge clk);
            start = (rel == 0) || (rel == st2);
            abort = (rel == ab);
            if (rs >= 0 && rel == rs) begin
                rst_n = 1'b0;
                #1;
                chk("rst_async_busy", int'(a_busy), 0);
                chk("rst_async_rd_en", int'(a_rd_en), 0);
                chk("rst_async_rd_col", int'(a_rd_col), 0);
                chk("rst_async_conv_en", int'(a_conv_en), 0);
                chk("rst_async_out_valid", int'(a_ov), 0);
            end
            if (rs >= 0 && rel == rs + 2) rst_n = 1'b1;
            if (a_rd_en) begin
                a_rd_n++;
                if (a_rd_first < 0) a_rd_first = rel;
                a_rd_last = rel;
            end
            if (a_ov) begin
                tg = tagv(int'(a_omap), int'(a_orow), int'(a_ocol));
                a_v_n++;
                if (a_v_first < 0) begin
                    a_v_first = rel;
                    a_v_first_tag = tg;
                end
                if (rel == 21) a_tag21 = tg;
                if (st2 > 0 && rel > st2 && a_v2_first < 0) begin
                    a_v2_first = rel;
                    a_v2_tag = tg;
                end
                a_v_last = rel;
                a_v_last_tag = tg;
            end
            if (a_done) begin
                a_done_n++;
                a_done_cyc = rel;
            end
            if (!a_busy && a_done_cyc >= 0 && a_busy_low < 0)
                a_busy_low = rel;
            if (b_ov) b_v_n++;
            if (rel == 141) b_ms141 = int'(b_msel);
            if (rel == 142) begin
                b_ms142 = int'(b_msel);
                b_ce142 = int'(b_conv_en);
            end
            if (b_ov && b_omap == 1'b1 && b_m1_first < 0) begin
                b_m1_first = rel;
                b_m1_tag = tagv(int'(b_omap), int'(b_orow), int'(b_ocol));
            end
            if (c_ov) begin
                c_v_n++;
                if (c_v_first < 0) begin
                    c_v_first = rel;
                    c_v_first_tag =
                        tagv(int'(c_omap), int'(c_orow), int'(c_ocol));
                end
                if (c_ocol > 4'd9) c_col_bad++;
            end
            if (ab >= 0 && rel > ab && rel <= st2 &&
                (a_rd_en || a_conv_en || a_ov || b_rd_en || b_conv_en ||
                 b_ov || c_rd_en || c_conv_en || c_ov))
                ab_bad++;
            if (rel < 200 && (a_done || b_done || c_done)) early_done++;
            if (rs >= 0 && rel >= rs &&
                (a_busy || a_rd_en || a_conv_en || a_ov || a_done ||
                 b_busy || b_ov || c_busy || c_conv_en || c_ov))
                rs_bad++;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(a_busy), 0);
        chk("reset_rd_en", int'(a_rd_en), 0);
        chk("reset_done", int'(a_done), 0);
        chk("reset_out_valid", int'(a_ov), 0);
        chk("reset_map_sel", int'(b_msel), 0);
        rst_n = 1'b1;

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_wins_busy", int'(a_busy), 0);
        @(negedge clk);
        chk("idle_abort_wins_rd_en", int'(a_rd_en), 0);

        // Plain pass
        run_pass(-1, -1, -1, 400);
        chk("a_rd_first", a_rd_first, 1);
        chk("a_rd_last", a_rd_last, 140);
        chk("a_rd_count", a_rd_n, 140);
        chk("a_results", a_v_n, 100);
        chk("a_first_cyc", a_v_first, 7);
        chk("a_first_tag", a_v_first_tag, tagv(0, 0, 0));
        chk("a_tag_cyc21", a_tag21, tagv(0, 1, 0));
        chk("a_last_cyc", a_v_last, 142);
        chk("a_last_tag", a_v_last_tag, tagv(0, 9, 9));
        chk("a_done_cyc", a_done_cyc, 143);
        chk("a_done_count", a_done_n, 1);
        chk("a_busy_low", a_busy_low, 144);
        chk("b_results", b_v_n, 200);
        chk("b_map_sel_141", b_ms141, 0);
        chk("b_map_sel_142", b_ms142, 1);
        chk("b_conv_en_142", b_ce142, 1);
        chk("b_map1_first_cyc", b_m1_first, 147);
        chk("b_map1_first_tag", b_m1_tag, tagv(1, 0, 0));
        chk("c_first_cyc", c_v_first, 8);
        chk("c_first_tag", c_v_first_tag, tagv(0, 0, 0));
        chk("c_results", c_v_n, 100);
        chk("c_col_range", c_col_bad, 0);

        // Second start while busy is ignored
        run_pass(50, -1, -1, 400);
        chk("restart_ign_results", a_v_n, 100);
        chk("restart_ign_first", a_v_first, 7);
        chk("restart_ign_last_tag", a_v_last_tag, tagv(0, 9, 9));
        chk("restart_ign_done", a_done_cyc, 143);
        chk("restart_ign_done_n", a_done_n, 1);
        chk("restart_ign_busy_low", a_busy_low, 144);

        // Abort at 60, fresh start at 70
        run_pass(70, 60, -1, 400);
        chk("abort_quiet", ab_bad, 0);
        chk("abort_no_done", early_done, 0);
        chk("abort_restart_cyc", a_v2_first, 77);
        chk("abort_restart_tag", a_v2_tag, tagv(0, 0, 0));
        chk("abort_restart_done", a_done_cyc, 213);
        chk("abort_done_n", a_done_n, 1);

        // Async reset at 30 for two cycles
        run_pass(-1, -1, 30, 60);
        chk("rst_pipe_empty", rs_bad, 0);
        chk("rst_no_done", a_done_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv554_sched.md
Name: conv554_sched

Overview:
- Sequencer for the 5x5x4 convolution datapath of the C3 layer.
- Walks a 4-channel IN_H x IN_W input feature-map buffer column by column, once per output row and once per output map.
- Issues buffer read requests and generates the datapath enable with matching latency.
- Masks window-fill columns and tags every valid convolution result with (map, row, col); start/busy/done handshake toward the layer controller.

Parameters:
- IN_W, 14, input map width (columns).
- IN_H, 14, input map height (rows).
- N_MAP, 16, output maps computed per start (filter/bias set index range).
- RD_LAT, 1, cycles from rd_en to column data at datapath inputs (>=1).
- CONV_LAT, 1, cycles from conv_en to valid convValue (>=0).
- Derived: OUT_W=IN_W-4, OUT_H=IN_H-4, COL_W=clog2(IN_W), ROW_W=clog2(IN_H), MAP_W=max(1,clog2(N_MAP)).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a layer pass when idle.
- abort  in  1  synchronous; kills current pass.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the last result.
- rd_en  out  1  read one 5-row column (rows rd_row..rd_row+4, all 4 channels).
- rd_row  out  ROW_W  top row of requested column.
- rd_col  out  COL_W  requested column.
- conv_en  out  1  datapath shift/compute enable (rd_en delayed RD_LAT).
- map_sel  out  MAP_W  filter/bias set select, aligned to conv_en.
- out_valid  out  1  convValue valid this cycle.
- out_map  out  MAP_W  result map index.
- out_row  out  ROW_W  result row, 0..OUT_H-1.
- out_col  out  COL_W  result column, 0..OUT_W-1.

Behaviour:
- Reset: state IDLE; all outputs 0; delay pipelines cleared.
- FSM IDLE -> RUN on start. RUN -> DRAIN after the final read. DRAIN -> DONE when the pipeline is empty. DONE -> IDLE after 1 cycle.
- DONE drives done=1; start in any non-IDLE state is ignored.
- RUN issues one read per cycle, no gaps. Loop order: map m (0..N_MAP-1) outer, row r (0..OUT_H-1), col c (0..IN_W-1) inner.
- In RUN: rd_en=1, rd_row=r, rd_col=c; total N_MAP*OUT_H*IN_W reads.
- Wrap: c==IN_W-1 -> c=0, r++. r==OUT_H-1 at wrap -> r=0, m++. Last read at (N_MAP-1, OUT_H-1, IN_W-1).
- Tag pipeline: {m, r, c} travels with rd_en through RD_LAT stages.
- conv_en and map_sel come from stage RD_LAT. map_sel holds its last value when conv_en=0.
- A further CONV_LAT stages produce out_valid/out_map/out_row/out_col.
- out_valid=1 only for tags with c>=4, with out_col=c-4. Columns 0..3 of every row refill the window and are masked.
- Timing, start sampled at cycle 0:
  - read k is issued at cycle 1+k;
  - conv_en for read k at cycle 1+k+RD_LAT;
  - result at cycle 1+k+RD_LAT+CONV_LAT;
  - done at the cycle after the last result;
  - busy falls with the return to IDLE.
- Row/map boundaries need no bubble: the window is overwritten by the 5 new columns and stale data is masked.
- abort (any non-IDLE state): next cycle IDLE; all pipeline valids cleared; no done pulse; rd_en/conv_en/out_valid low from that cycle.
- abort and start in the same cycle while IDLE: abort wins, stays IDLE.
- Async reset mid-pass: same end state as abort, immediately.

Decomposition:
- Shared layer package holds:
  - the FSM state enum (IDLE, RUN, DRAIN, DONE);
  - the tag struct {map, row, col};
  - the kernel-size constant 5 and the channel count 4.
- One sub-module: tag_delay_line (parameterised depth, valid plus tag). It is instantiated twice, for RD_LAT and CONV_LAT; depth 0 is a wire.

Test Plan:
- N_MAP=1, defaults, start at cycle 0:
  - rd_en high cycles 1..140;
  - exactly 100 out_valid pulses;
  - first at cycle 7 = (0,0,0);
  - (0,1,0) at cycle 21;
  - last (0,9,9) at cycle 142;
  - done at cycle 143;
  - busy low at 144.
- N_MAP=2:
  - map_sel changes 0->1 on the conv_en of read 140 (cycle 142);
  - first out_map=1 result (1,0,0) at cycle 147;
  - 200 results total.
- start pulsed again at cycle 50: ignored; sequence identical to the first test.
- abort at cycle 60:
  - rd_en, conv_en and out_valid low from cycle 61;
  - no done;
  - a new start at 70 gives a first result 7 cycles later at (0,0,0).
- rst_n low at cycle 30 for 2 cycles:
  - all outputs 0 asynchronously;
  - the pipeline is empty after release.
- RD_LAT=3, CONV_LAT=0: first result at cycle 8; every out_col in 0..9 and never emitted for input columns 0..3.
